selector_sprite_blitter: RTL and testbench
==========================================

// Module: selector_sprite_blitter
// PURPOSE
//  Sequences the 66x59 selector sprite ROM and writes it into the frame buffer.
//  A start request latches an origin (x0,y0) and walks the ROM row by row.
//  The block emits one pixel write per column over a valid/ready handshake, with
//  screen coordinates already offset. It sits between the game-state logic and
//  the frame-buffer write port, and is the only driver of the ROM address.
// PARAMETERS
//  ROWS       66   sprite rows (ROM depth used, addresses 0..ROWS-1)
//  COLS       59   sprite columns (ROM word width)
//  AW         7    ROM address width
//  XW         10   screen x coordinate width
//  YW         10   screen y coordinate width
//  SKIP_ZERO  0    1: columns whose bit is 0 take one cycle but emit no write
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     begin blit; sampled only in IDLE
//  abort      in   1     synchronous cancel; returns to IDLE, no done
//  x0         in   XW    sprite origin x, latched on accepted start
//  y0         in   YW    sprite origin y, latched on accepted start
//  busy       out  1     high from the cycle after start until IDLE
//  done       out  1     one-cycle pulse after last pixel handshake
//  rom_addr   out  AW    sprite ROM row address
//  rom_data   in   COLS  ROM word; combinational from rom_addr
//  px_valid   out  1     pixel write request
//  px_ready   in   1     frame buffer accepts the pixel this cycle
//  px_x       out  XW    (x0 + col) mod 2^XW
//  px_y       out  YW    (y0 + row) mod 2^YW
//  px_on      out  1     sprite bit: rom_data[COLS-1-col] as latched
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, px_valid, px_on = 0;
//   rom_addr, px_x, px_y, row, col = 0; row buffer cleared.
//  FSM IDLE -> FETCH -> SCAN -> (FETCH | DONE) -> IDLE.
//   IDLE:  start=1 latches x0/y0, row=0, goes to FETCH. start is ignored
//          in every other state.
//   FETCH: rom_addr=row (1 cycle). rom_data is registered into row_buf at
//          the cycle end. col=0, then SCAN.
//   SCAN:  one column per cycle, col 0 = rom MSB (leftmost pixel).
//          Bit 1, or SKIP_ZERO=0: px_valid=1 and px_x/px_y/px_on stay stable
//          until px_ready=1. The column advances on the handshake.
//          Bit 0 and SKIP_ZERO=1: px_valid=0, column advances that cycle.
//          After col COLS-1: row<ROWS-1 -> row+1, FETCH. Otherwise -> DONE.
//   DONE:  done=1 and busy=0 for exactly 1 cycle, then IDLE. A start in
//          that cycle is ignored.
//  px_valid is never dropped without a handshake, except on abort or reset.
//  Latency with px_ready=1 and SKIP_ZERO=0:
//   first px_valid 2 cycles after the start edge;
//   ROWS*(COLS+1)=3960 cycles from start edge to last handshake;
//   done on the next cycle.
//  Coordinate adds wrap modulo 2^XW / 2^YW; there is no clipping.
//  abort=1 in any non-IDLE state: next cycle IDLE, px_valid=0, busy=0, done
//   stays 0. abort has priority over px_ready in the same cycle.
//  rst_n deassert mid-blit: the blit is lost. Restart requires a new start.
//  rom_addr holds its last value outside FETCH, with no glitching to the ROM.
// TESTING
//  1 Reset: rst_n=0 mid-SCAN, with no clock edge -> busy, px_valid, done = 0
//    immediately; state=IDLE after release.
//  2 Full blit, SKIP_ZERO=0, px_ready=1, origin (0,0) -> 3894 writes;
//    first (0,0,on=0); row 0 on only for x=26..32; done 3961 cycles after start.
//  3 Backpressure: px_ready=0 for 5 cycles at the first pixel -> px_valid
//    and the pixel fields are held unchanged; 1 write on release; total +5 cycles.
//  4 SKIP_ZERO=1, origin (100,40) -> row 0 emits exactly 7 writes, x=126..132,
//    y=40; row 17 emits x=100,101,157,158, y=57; done pulses once.
//  5 Wrap: x0=1020, y0=1000 -> row 0 col 26 gives px_x=22, px_y=1000;
//    row 65 gives px_y=41.
//  6 Abort in row 30 with a pending px_valid -> IDLE next cycle, no done;
//    start during busy is ignored; a new start redraws from row 0.

Source files
------------

// File: rtl/selector_sprite_blitter_if.sv
// Pixel write channel from the sprite blitter to the frame buffer:
// valid/ready handshake carrying screen coordinates and the sprite bit.
interface selector_sprite_blitter_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          px_valid;
  logic          px_ready;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic          px_on;

  modport master (
    output px_valid, px_x, px_y, px_on,
    input  px_ready
  );

  modport slave (
    input  px_valid, px_x, px_y, px_on,
    output px_ready
  );
endinterface

// File: rtl/selector_sprite_blitter.sv
// Walks the selector sprite ROM row by row and streams one offset
// pixel write per column into the frame buffer.
module selector_sprite_blitter #(
  parameter int ROWS      = 66,
  parameter int COLS      = 59,
  parameter int AW        = 7,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int SKIP_ZERO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XW-1:0]   x0,
  input  logic [YW-1:0]   y0,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   rom_addr,
  input  logic [COLS-1:0] rom_data,
  selector_sprite_blitter_if.master px
);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    IDLE, FETCH, SCAN, FIN
  } state_t;

  state_t          state;
  logic [XW-1:0]   xo;
  logic [YW-1:0]   yo;
  logic [AW-1:0]   row;
  logic [CW-1:0]   col;
  logic [CW-1:0]   ncol;
  logic [COLS-1:0] row_buf;
  logic [COLS-1:0] shifted;
  logic            nbit;
  logic            adv;
  logic            last_col;
  logic            last_row;

  // Next column's bit sits at the MSB once shifted left by its index.
  assign ncol     = col + 1'b1;
  assign shifted  = row_buf << ncol;
  assign nbit     = shifted[COLS-1];
  assign adv      = !px.px_valid || px.px_ready;
  assign last_col = col == CW'(COLS - 1);
  assign last_row = row == AW'(ROWS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_addr    <= '0;
      row         <= '0;
      col         <= '0;
      row_buf     <= '0;
      xo          <= '0;
      yo          <= '0;
      px.px_valid <= 1'b0;
      px.px_x     <= '0;
      px.px_y     <= '0;
      px.px_on    <= 1'b0;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      px.px_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xo       <= x0;
            yo       <= y0;
            row      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          row_buf     <= rom_data;
          col         <= '0;
          px.px_x     <= xo;
          px.px_y     <= yo + YW'(row);
          px.px_on    <= rom_data[COLS-1];
          px.px_valid <= (SKIP_ZERO == 0) || rom_data[COLS-1];
          state       <= SCAN;
        end
        SCAN: begin
          if (adv) begin
            if (last_col) begin
              px.px_valid <= 1'b0;
              if (last_row) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                row      <= row + 1'b1;
                rom_addr <= row + 1'b1;
                state    <= FETCH;
              end
            end else begin
              col         <= ncol;
              px.px_x     <= xo + XW'(ncol);
              px.px_on    <= nbit;
              px.px_valid <= (SKIP_ZERO == 0) || nbit;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_selector_sprite_blitter.sv
// Bench for the selector sprite blitter: two instances (SKIP_ZERO 0/1)
// against a queue model of the expected pixel writes.
module tb_selector_sprite_blitter;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic        abort [2];
  logic        busy [2];
  logic        dn [2];
  logic        v [2];
  logic        rdy [2];
  logic        pon [2];
  logic [9:0]  x0 [2];
  logic [9:0]  y0 [2];
  logic [9:0]  px [2];
  logic [9:0]  py [2];
  logic [6:0]  addr [2];
  logic [58:0] rdata [2];
  logic [58:0] rom_tbl [128];

  int   checks = 0;
  int   failures = 0;
  int   r0x[$];
  int   r17x[$];
  pix_t firstp;

  always #5 clk = ~clk;

  selector_sprite_blitter_if #(.XW(10), .YW(10)) if0 ();
  selector_sprite_blitter_if #(.XW(10), .YW(10)) if1 ();

  assign v[0] = if0.px_valid;
  assign px[0] = if0.px_x;
  assign py[0] = if0.px_y;
  assign pon[0] = if0.px_on;
  assign if0.px_ready = rdy[0];
  assign v[1] = if1.px_valid;
  assign px[1] = if1.px_x;
  assign py[1] = if1.px_y;
  assign pon[1] = if1.px_on;
  assign if1.px_ready = rdy[1];
  assign rdata[0] = rom_tbl[addr[0]];
  assign rdata[1] = rom_tbl[addr[1]];

  selector_sprite_blitter #(.SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .x0(x0[0]), .y0(y0[0]), .busy(busy[0]), .done(dn[0]),
    .rom_addr(addr[0]), .rom_data(rdata[0]), .px(if0)
  );

  selector_sprite_blitter #(.SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .x0(x0[1]), .y0(y0[1]), .busy(busy[1]), .done(dn[1]),
    .rom_addr(addr[1]), .rom_data(rdata[1]), .px(if1)
  );

  function automatic void chk(input string nm, input longint got,
                              input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endfunction

  // Model: an accepted start queues every write the blit must make.
  for (genvar g = 0; g < 2; g++) begin : model
    pix_t q[$];
    pix_t p;
    bit   act = 0;
    bit   held = 0;

    always @(posedge clk) begin
      held = act && v[g] && !rdy[g] && !abort[g] && rst_n;
      if (!rst_n) begin
        q.delete();
        act = 0;
      end else if (act && abort[g]) begin
        q.delete();
        act = 0;
      end else if (act && dn[g]) begin
        act = 0;
      end else begin
        if (v[g] && rdy[g] && q.size() > 0) void'(q.pop_front());
        if (!act && start[g]) begin
          act = 1;
          q.delete();
          for (int r = 0; r < 66; r++)
            for (int c = 0; c < 59; c++) begin
              p.on = rom_tbl[r][58-c];
              p.x = x0[g] + 10'(c);
              p.y = y0[g] + 10'(r);
              if (g == 0 || p.on) q.push_back(p);
            end
        end
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (v[g]) begin
          if (q.size() == 0) chk($sformatf("spurious_valid%0d", g), 1, 0);
          else chk($sformatf("pixel%0d", g), {px[g], py[g], pon[g]}, q[0]);
        end
        if (held) chk($sformatf("valid_held%0d", g), v[g], 1);
        chk($sformatf("busy%0d", g), busy[g], act && !dn[g]);
        if (dn[g]) chk($sformatf("done_ok%0d", g), act && q.size() == 0, 1);
      end
    end
  end

  task automatic run_blit(input int g, input int xs, input int ys,
                          input int hold, output int first_v,
                          output int last_hs, output int done_at,
                          output int nwr, output int last_y);
    int   n;
    pix_t cap;
    first_v = -1;
    last_hs = -1;
    done_at = -1;
    nwr = 0;
    last_y = -1;
    r0x.delete();
    r17x.delete();
    rdy[g] = 1;
    x0[g] = 10'(xs);
    y0[g] = 10'(ys);
    start[g] = 1;
    @(negedge clk);
    start[g] = 0;
    n = 0;
    while (done_at < 0 && n < 5000) begin
      if (v[g] && first_v < 0) begin
        first_v = n;
        firstp = {px[g], py[g], pon[g]};
        if (hold > 0) begin
          rdy[g] = 0;
          cap = {px[g], py[g], pon[g]};
          repeat (hold) begin
            @(negedge clk);
            n++;
            chk("hold_valid", v[g], 1);
            chk("hold_fields", {px[g], py[g], pon[g]}, cap);
          end
          rdy[g] = 1;
        end
      end
      if (v[g] && rdy[g]) begin
        nwr++;
        last_hs = n + 1;
        last_y = py[g];
        if (pon[g] && py[g] == 10'(ys)) r0x.push_back(px[g]);
        if (pon[g] && py[g] == 10'(ys + 17)) r17x.push_back(px[g]);
      end
      if (dn[g]) done_at = n;
      @(negedge clk);
      n++;
    end
    if (done_at < 0) chk("done_timeout", 0, 1);
    chk("done_single", dn[g], 0);
  endtask

  initial begin
    logic [63:0] w;
    int fv, lh, da, nw, ly, n, ones;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0;
      abort[i] = 0;
      rdy[i] = 1;
      x0[i] = '0;
      y0[i] = '0;
    end
    for (int r = 0; r < 128; r++) begin
      w = {$urandom, $urandom};
      rom_tbl[r] = w[58:0];
    end
    rom_tbl[0] = '0;
    for (int c = 26; c <= 32; c++) rom_tbl[0][58-c] = 1'b1;
    rom_tbl[17] = '0;
    rom_tbl[17][58] = 1'b1;
    rom_tbl[17][57] = 1'b1;
    rom_tbl[17][1] = 1'b1;
    rom_tbl[17][0] = 1'b1;
    ones = 0;
    for (int r = 0; r < 66; r++) ones += $countones(rom_tbl[r]);

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_done", dn[i], 0);
      chk("rst_valid", v[i], 0);
      chk("rst_addr", addr[i], 0);
      chk("rst_pix", {px[i], py[i], pon[i]}, 0);
    end

    // Full blit, no backpressure
    run_blit(0, 0, 0, 0, fv, lh, da, nw, ly);
    chk("t2_first_v", fv, 1);
    chk("t2_first_pix", firstp, 0);
    chk("t2_last_hs", lh, 3960);
    chk("t2_done_at", da, 3960);
    chk("t2_writes", nw, 3894);
    chk("t2_row0_n", r0x.size(), 7);
    if (r0x.size() == 7) begin
      chk("t2_row0_lo", r0x[0], 26);
      chk("t2_row0_hi", r0x[6], 32);
    end

    // Backpressure at first pixel
    run_blit(0, 5, 7, 5, fv, lh, da, nw, ly);
    chk("t3_first_v", fv, 1);
    chk("t3_last_hs", lh, 3965);
    chk("t3_done_at", da, 3965);
    chk("t3_writes", nw, 3894);

    // Zero skipping
    run_blit(1, 100, 40, 0, fv, lh, da, nw, ly);
    chk("t4_done_at", da, 3960);
    chk("t4_writes", nw, ones);
    chk("t4_row0_n", r0x.size(), 7);
    if (r0x.size() == 7) begin
      chk("t4_row0_lo", r0x[0], 126);
      chk("t4_row0_hi", r0x[6], 132);
    end
    chk("t4_row17_n", r17x.size(), 4);
    if (r17x.size() == 4) begin
      chk("t4_row17_a", r17x[0], 100);
      chk("t4_row17_b", r17x[1], 101);
      chk("t4_row17_c", r17x[2], 157);
      chk("t4_row17_d", r17x[3], 158);
    end

    // Coordinate wrap
    run_blit(0, 1020, 1000, 0, fv, lh, da, nw, ly);
    chk("t5_row0_x", r0x.size() > 0 ? r0x[0] : -1, 22);
    chk("t5_last_y", ly, 41);
    chk("t5_writes", nw, 3894);

    // Abort in row 30, start during busy ignored
    x0[0] = 10'd3;
    y0[0] = 10'd4;
    start[0] = 1;
    @(negedge clk);
    start[0] = 0;
    n = 0;
    while (!(v[0] && py[0] == 10'd34) && n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 500) begin
        start[0] = 1;
        x0[0] = 10'd9;
        y0[0] = 10'd9;
      end else begin
        start[0] = 0;
      end
    end
    chk("t6_row30", v[0] && py[0] == 10'd34, 1);
    rdy[0] = 0;
    @(negedge clk);
    chk("t6_pending", v[0], 1);
    abort[0] = 1;
    rdy[0] = 1;
    @(negedge clk);
    abort[0] = 0;
    chk("t6_busy", busy[0], 0);
    chk("t6_valid", v[0], 0);
    repeat (5) begin
      chk("t6_no_done", dn[0], 0);
      @(negedge clk);
    end
    run_blit(0, 1, 2, 0, fv, lh, da, nw, ly);
    chk("t6_first_v", fv, 1);
    chk("t6_first_pix", firstp, {10'd1, 10'd2, 1'b0});
    chk("t6_done_at", da, 3960);

    // Asynchronous reset mid-scan
    x0[0] = 10'd50;
    y0[0] = 10'd60;
    start[0] = 1;
    @(negedge clk);
    start[0] = 0;
    repeat (100) @(negedge clk);
    chk("t1_pre_valid", v[0], 1);
    #2 rst_n = 0;
    #1;
    chk("t1_busy", busy[0], 0);
    chk("t1_valid", v[0], 0);
    chk("t1_done", dn[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_idle_valid", v[0], 0);
      chk("t1_idle_busy", busy[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
